// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern selector: manual/auto pattern changes take effect
// only on frame_tick, followed by BLANK_FRAMES frames of forced black.
module vga_pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned AUTO_FRAMES  = 120,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             next_req,
    input  logic             prev_req,
    input  logic             auto_en,
    output logic [SEL_W-1:0] pattern_sel,
    output logic             blank_force,
    output logic             switch_busy,
    output logic             pattern_changed
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_FRAMES);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] sel_inc, sel_dec;
    logic             blank_q, blank_d;
    logic             busy_q, busy_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
    logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic             dir_q, dir_d;        // 0 = forward, 1 = backward
    logic             req_valid;
    logic             req_dir;
    logic             auto_hit;
    logic             apply;
    logic             apply_dir;

    assign req_valid = next_req ^ prev_req;
    assign req_dir   = prev_req;
    assign auto_hit  = auto_en && (auto_cnt_q == AUTO_LAST);
    assign sel_inc   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    assign sel_dec   = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        blank_d     = blank_q;
        changed_d   = 1'b0;
        auto_cnt_d  = auto_cnt_q;
        blank_cnt_d = blank_cnt_q;
        dir_d       = dir_q;
        apply       = 1'b0;
        apply_dir   = dir_q;

        case (state_q)
            RUN: begin
                if (!auto_en) begin
                    auto_cnt_d = '0;
                end else if (frame_tick) begin
                    auto_cnt_d = auto_cnt_q + CNT_W'(1);
                end
                if (req_valid) begin
                    dir_d = req_dir;
                    if (frame_tick) begin
                        apply     = 1'b1;
                        apply_dir = req_dir;
                    end else begin
                        state_d = PEND;
                    end
                end else if (frame_tick && auto_hit) begin
                    dir_d     = 1'b0;
                    apply     = 1'b1;
                    apply_dir = 1'b0;
                end
            end
            PEND: begin
                // A request on the tick cycle itself still wins over the latched direction.
                if (req_valid) begin
                    dir_d = req_dir;
                end
                if (frame_tick) begin
                    apply     = 1'b1;
                    apply_dir = req_valid ? req_dir : dir_q;
                end
            end
            BLANK: begin
                auto_cnt_d = '0;
                if (frame_tick) begin
                    if (blank_cnt_q == CNT_W'(1)) begin
                        blank_cnt_d = '0;
                        blank_d     = 1'b0;
                        changed_d   = 1'b1;
                        state_d     = RUN;
                    end else begin
                        blank_cnt_d = blank_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (apply) begin
            sel_d      = apply_dir ? sel_dec : sel_inc;
            auto_cnt_d = '0;
            if (BLANK_FRAMES == 0) begin
                state_d   = RUN;
                blank_d   = 1'b0;
                changed_d = 1'b1;
            end else begin
                state_d     = BLANK;
                blank_d     = 1'b1;
                blank_cnt_d = BLANK_LOAD;
            end
        end
    end

    assign busy_d = (state_d != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            sel_q       <= '0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
            changed_q   <= 1'b0;
            auto_cnt_q  <= '0;
            blank_cnt_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
            changed_q   <= changed_d;
            auto_cnt_q  <= auto_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            dir_q       <= dir_d;
        end
    end

    assign pattern_sel     = sel_q;
    assign blank_force     = blank_q;
    assign switch_busy     = busy_q;
    assign pattern_changed = changed_q;

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Frame-synchronous controller that selects which test pattern feeds the VGA pixel path.
- Takes manual next/prev requests and an optional auto-cycle timer.
- Applies every pattern change only at a frame boundary, then forces black for a fixed number of frames so the monitor never shows a torn or partial pattern.
- Sits between the board-level button/switch logic and the pattern mux in front of the RGB output stage.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns (2..2**SEL_W; need not be a power of two)
SEL_W, 2, width of pattern_sel
AUTO_FRAMES, 120, frames each pattern is shown in auto mode (>=1)
BLANK_FRAMES, 2, black frames inserted after each switch (0 = no blanking)
CNT_W, 8, width of the auto and blank frame counters (must hold AUTO_FRAMES and BLANK_FRAMES)

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous reset, active-high
frame_tick  input  1  one-cycle pulse at the first blanking line after active video (y == V_ACTIVE, x == 0)
next_req  input  1  one-cycle pulse, already debounced: advance pattern
prev_req  input  1  one-cycle pulse, already debounced: go back one pattern
auto_en  input  1  level: enable auto-cycling
pattern_sel  output  SEL_W  current pattern index to the pattern mux
blank_force  output  1  1 = downstream drives rgb = 12'h000 regardless of DE
switch_busy  output  1  1 while a switch is pending or blanking (state != RUN)
pattern_changed  output  1  one-cycle pulse when blanking ends and the new pattern becomes visible

Behaviour:
- Reset values (asynchronous): state RUN, pattern_sel 0, blank_force 0, switch_busy 0, pattern_changed 0, auto_cnt 0, blank_cnt 0, dir 0.
- Reset asserted mid-switch discards the pending direction and any blanking immediately.
- All outputs are registered. Effects of an input sampled at edge N are visible after edge N.
- Request decode: next_req && prev_req in the same cycle = no request. Otherwise dir = +1 (next) or -1 (prev).
- Wrap-around: next from NUM_PATTERNS-1 gives 0; prev from 0 gives NUM_PATTERNS-1. pattern_sel never reaches a value >= NUM_PATTERNS.
- RUN state:
  - Manual request without frame_tick: latch dir, go to PEND.
  - Manual request coincident with frame_tick: apply the switch at this tick (see "Apply").
  - With auto_en=1, auto_cnt increments on each frame_tick.
  - frame_tick with auto_cnt == AUTO_FRAMES-1 and no manual request: auto switch, dir = +1, apply at this tick.
  - auto_en=0 holds auto_cnt at 0.
- PEND state: a new manual request overwrites dir (last wins; a simultaneous next+prev leaves dir unchanged). On frame_tick: apply.
- Apply:
  - Update pattern_sel by dir and clear auto_cnt.
  - If BLANK_FRAMES == 0: stay in or return to RUN, pulse pattern_changed, blank_force stays 0.
  - Otherwise: set blank_force=1, load blank_cnt = BLANK_FRAMES, enter BLANK.
- BLANK state: each frame_tick decrements blank_cnt. The frame_tick that sees blank_cnt == 1 clears blank_force, pulses pattern_changed, and returns to RUN. Requests arriving in BLANK are dropped. auto_cnt is held at 0.
- Blanking covers exactly BLANK_FRAMES full frames starting with the frame after the switching tick.
- switch_busy = (state != RUN), registered with the state.
- Toggling auto_en in PEND or BLANK has no effect until RUN.

Test Plan:
(Bench parameters: NUM_PATTERNS=3, AUTO_FRAMES=4, BLANK_FRAMES=2, frame_tick every 100 cycles.)
- Reset, then next_req at cycle 10 -> switch_busy=1 from cycle 11; at first tick pattern_sel=1, blank_force=1; blank_force=0 and pattern_changed=1 for one cycle at the second tick after that; switch_busy=0.
- From pattern_sel=0, prev_req -> pattern_sel=2; three next switches from 0 -> sequence 1,2,0.
- next_req and prev_req asserted in the same cycle in RUN -> state stays RUN, no change; next_req followed by prev_req while in PEND -> switch applies dir -1.
- auto_en=1 held, no buttons -> pattern_sel advances on ticks 4, 10, 16 (4 frames shown + 2 blank each); next_req during BLANK -> ignored, sequence unchanged.
- next_req coincident with frame_tick in RUN -> pattern_sel updates on the next edge, no PEND cycle.
- Reset asserted in BLANK -> all outputs 0 asynchronously; after release the first frame_tick causes no switch.
